// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: operand/result handshake bundle for pipelined_barrel_shifter.
// The slave modport is the shifter, the master modport is whoever feeds and drains it.
// out_overflow only exists when PIPELINED_BARREL_SHIFTER_OVERFLOW_EN is defined.
interface pipelined_barrel_shifter_if #(
   parameter int WIDTH     = 13,
   parameter int TAG_WIDTH = 4
);
   localparam int SHIFT_BITS = $clog2(WIDTH);

   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      in_data;
   logic [SHIFT_BITS-1:0] in_shift;
   logic [1:0]            in_mode;
   logic [TAG_WIDTH-1:0]  in_tag;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      out_data;
   logic [TAG_WIDTH-1:0]  out_tag;
`ifdef PIPELINED_BARREL_SHIFTER_OVERFLOW_EN
   logic                  out_overflow;

   modport master (
      output in_valid, in_data, in_shift, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_overflow
   );

   modport slave (
      input  in_valid, in_data, in_shift, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_overflow
   );
`else
   modport master (
      output in_valid, in_data, in_shift, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_shift, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
`endif
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: multi-mode (SHL, SHR, ROL, SRA) barrel shifter split into
// STAGES register stages, each resolving RADIX_BITS of the shift amount, most-significant
// digit first. A tag rides along with every operand and every stage can stall on its own,
// so bubbles collapse while the output is backpressured.
// Optional feature macro: PIPELINED_BARREL_SHIFTER_OVERFLOW_EN adds out_overflow, which
// flags set bits lost by SHL or non-sign bits lost by SRA.
module pipelined_barrel_shifter #(
   parameter int WIDTH      = 13,
   parameter int RADIX_BITS = 2,
   parameter int TAG_WIDTH  = 4
) (
   input logic clk,
   input logic reset_n,
   pipelined_barrel_shifter_if.slave bus
);
   localparam int SHIFT_BITS = $clog2(WIDTH);
   localparam int STAGES     = (SHIFT_BITS + RADIX_BITS - 1) / RADIX_BITS;
   localparam int PAD_BITS   = STAGES * RADIX_BITS;
   // one spare bit so WIDTH itself is representable when WIDTH is a power of two
   localparam int AMT_BITS   = PAD_BITS + 1;
   localparam logic [AMT_BITS-1:0] WIDTH_AMT = AMT_BITS'(WIDTH);

   // One stage worth of shifting; amounts of WIDTH or more saturate, rotation wraps modulo WIDTH.
   // SRA fills from the current MSB, which always still equals the operand's original sign bit.
   function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                    input logic [1:0] mode,
                                                    input logic [AMT_BITS-1:0] amt);
      logic [WIDTH-1:0]    res;
      logic [2*WIDTH-1:0]  dbl;
      logic [AMT_BITS-1:0] rot;
      res = d;
      rot = amt % WIDTH_AMT;
      dbl = {d, d} << rot;
      case (mode)
         2'd0:    res = (amt >= WIDTH_AMT) ? '0 : (d << amt);
         2'd1:    res = (amt >= WIDTH_AMT) ? '0 : (d >> amt);
         2'd2:    res = dbl[2*WIDTH-1:WIDTH];
         default: res = (amt >= WIDTH_AMT) ? {WIDTH{d[WIDTH-1]}} : $unsigned($signed(d) >>> amt);
      endcase
      return res;
   endfunction

`ifdef PIPELINED_BARREL_SHIFTER_OVERFLOW_EN
   // Bits this stage throws away: top bits for SHL, low bits that differ from the sign for SRA.
   function automatic logic stage_overflow(input logic [WIDTH-1:0] d,
                                           input logic [1:0] mode,
                                           input logic [AMT_BITS-1:0] amt);
      logic [WIDTH-1:0] ones;
      logic [WIDTH-1:0] lost;
      ones = '1;
      lost = '0;
      case (mode)
         2'd0:    lost = (amt >= WIDTH_AMT) ? d : (d & ~(ones >> amt));
         2'd3:    lost = (amt >= WIDTH_AMT) ? (d ^ {WIDTH{d[WIDTH-1]}})
                                            : ((d ^ {WIDTH{d[WIDTH-1]}}) & ~(ones << amt));
         default: lost = '0;
      endcase
      return |lost;
   endfunction
`endif

   logic [STAGES-1:0]    st_valid;
   logic [WIDTH-1:0]     st_data  [STAGES];
   logic [TAG_WIDTH-1:0] st_tag   [STAGES];
   logic [1:0]           st_mode  [STAGES];
   logic [PAD_BITS-1:0]  st_shift [STAGES];

   logic [STAGES-1:0]    src_valid;
   logic [WIDTH-1:0]     src_data  [STAGES];
   logic [TAG_WIDTH-1:0] src_tag   [STAGES];
   logic [1:0]           src_mode  [STAGES];
   logic [PAD_BITS-1:0]  src_shift [STAGES];
   logic [AMT_BITS-1:0]  amt       [STAGES];
   logic [WIDTH-1:0]     nxt_data  [STAGES];
   logic [STAGES-1:0]    load;

`ifdef PIPELINED_BARREL_SHIFTER_OVERFLOW_EN
   logic [STAGES-1:0]    st_ovf;
   logic [STAGES-1:0]    src_ovf;
   logic [STAGES-1:0]    nxt_ovf;
`endif

   // Stage inputs come from the port for stage 0 and from the previous register otherwise;
   // each stage picks its own digit of the zero-padded shift amount and weights it.
   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_head
         assign src_valid[s] = bus.in_valid;
         assign src_data[s]  = bus.in_data;
         assign src_tag[s]   = bus.in_tag;
         assign src_mode[s]  = bus.in_mode;
         assign src_shift[s] = PAD_BITS'(bus.in_shift);
`ifdef PIPELINED_BARREL_SHIFTER_OVERFLOW_EN
         assign src_ovf[s]   = 1'b0;
`endif
      end else begin : g_body
         assign src_valid[s] = st_valid[s-1];
         assign src_data[s]  = st_data[s-1];
         assign src_tag[s]   = st_tag[s-1];
         assign src_mode[s]  = st_mode[s-1];
         assign src_shift[s] = st_shift[s-1];
`ifdef PIPELINED_BARREL_SHIFTER_OVERFLOW_EN
         assign src_ovf[s]   = st_ovf[s-1];
`endif
      end
      assign amt[s] = AMT_BITS'(src_shift[s][PAD_BITS-1-RADIX_BITS*s -: RADIX_BITS])
                      << (RADIX_BITS * (STAGES - 1 - s));
      assign nxt_data[s] = stage_shift(src_data[s], src_mode[s], amt[s]);
`ifdef PIPELINED_BARREL_SHIFTER_OVERFLOW_EN
      assign nxt_ovf[s] = src_ovf[s] | stage_overflow(src_data[s], src_mode[s], amt[s]);
`endif
   end

   // A stage may load when the output is being taken or when it or any later stage is empty.
   always_comb begin
      load = '0;
      for (int s = 0; s < STAGES; s++) begin
         load[s] = bus.out_ready;
         for (int k = s; k < STAGES; k++) begin
            if (!st_valid[k]) begin
               load[s] = 1'b1;
            end
         end
      end
   end

   // Pipeline registers: a loading stage takes its upstream valid, and its payload only when valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_valid <= '0;
`ifdef PIPELINED_BARREL_SHIFTER_OVERFLOW_EN
         st_ovf   <= '0;
`endif
         for (int s = 0; s < STAGES; s++) begin
            st_data[s]  <= '0;
            st_tag[s]   <= '0;
            st_mode[s]  <= '0;
            st_shift[s] <= '0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (load[s]) begin
               st_valid[s] <= src_valid[s];
               if (src_valid[s]) begin
                  st_data[s]  <= nxt_data[s];
                  st_tag[s]   <= src_tag[s];
                  st_mode[s]  <= src_mode[s];
                  st_shift[s] <= src_shift[s];
`ifdef PIPELINED_BARREL_SHIFTER_OVERFLOW_EN
                  st_ovf[s]   <= nxt_ovf[s];
`endif
               end
            end
         end
      end
   end

   assign bus.in_ready  = load[0];
   assign bus.out_valid = st_valid[STAGES-1];
   assign bus.out_data  = st_data[STAGES-1];
   assign bus.out_tag   = st_tag[STAGES-1];
`ifdef PIPELINED_BARREL_SHIFTER_OVERFLOW_EN
   assign bus.out_overflow = st_ovf[STAGES-1];
`endif
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed and randomized checks of pipelined_barrel_shifter
// (WIDTH=13, RADIX_BITS=2, two stages) against an integer-arithmetic reference model.
// Define PIPELINED_BARREL_SHIFTER_OVERFLOW_EN to also check out_overflow.
module tb_pipelined_barrel_shifter;
   localparam int W      = 13;
   localparam int TW     = 4;
   localparam int SB     = 4;
   localparam int STAGES = 2;
   localparam longint MASK = (longint'(1) << W) - 1;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   pipelined_barrel_shifter_if #(.WIDTH(W), .TAG_WIDTH(TW)) bus ();

   pipelined_barrel_shifter #(.WIDTH(W), .RADIX_BITS(2), .TAG_WIDTH(TW)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]  data;
      logic [TW-1:0] tag;
      logic          ovf;
   } exp_t;

   exp_t sb[$];
   logic prev_stall = 1'b0;
   logic [W-1:0]  prev_data = '0;
   logic [TW-1:0] prev_tag  = '0;
   logic last_ovf = 1'b0;

   // Reference: the whole shift done at once with integer arithmetic
   function automatic logic [W-1:0] model_data(input logic [W-1:0] d, input int sh, input int m);
      longint v;
      longint sv;
      v = longint'(d);
      case (m)
         0: v = (sh >= W) ? 0 : ((v << sh) & MASK);
         1: v = (sh >= W) ? 0 : (v >> sh);
         2: for (int i = 0; i < sh; i++) v = ((v << 1) | (v >> (W - 1))) & MASK;
         default: begin
            sv = d[W-1] ? (v - (longint'(1) << W)) : v;
            v  = (sv >>> sh) & MASK;
         end
      endcase
      return v[W-1:0];
   endfunction

   // Reference overflow: SHL loses set bits, SRA loses bits unlike the sign
   function automatic logic model_ovf(input logic [W-1:0] d, input int sh, input int m);
      logic r;
      r = 1'b0;
      if (m == 0) begin
         if (sh >= W) r = (d != 0);
         else         r = (((longint'(d) << sh) >> W) != 0);
      end else if (m == 3) begin
         for (int i = 0; i < sh && i < W; i++) if (d[i] != d[W-1]) r = 1'b1;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   // Present one operand from the post-edge phase and hold it until accepted
   task automatic applyStimulus(input logic [W-1:0] d, input int sh, input int m, input int t);
      int guard;
      guard = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_shift = SB'(sh);
      bus.in_mode  = 2'(m);
      bus.in_tag   = TW'(t);
      @(negedge clk);
      while (!bus.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) checkOutput("accept_timeout", 32'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Single operand into an idle pipeline: latency plus hand-computed result
   task automatic directedOp(input string name, input logic [W-1:0] d, input int sh, input int m,
                             input int t, input logic [W-1:0] exp_data);
      int n;
      logic seen;
      n = 0;
      seen = 1'b0;
      applyStimulus(d, sh, m, t);
      while (!seen && n < 10) begin
         @(negedge clk);
         n++;
         if (bus.out_valid) seen = 1'b1;
      end
      checkOutput({name, "_latency"}, 32'(n), STAGES);
      checkOutput({name, "_data"}, 32'(bus.out_data), 32'(exp_data));
      checkOutput({name, "_tag"}, 32'(bus.out_tag), 32'(t));
`ifdef PIPELINED_BARREL_SHIFTER_OVERFLOW_EN
      last_ovf = bus.out_overflow;
`endif
      @(posedge clk);
      #1;
   endtask

   // Scoreboard and hold checker: record accepted operands, compare delivered results in order
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checkOutput("hold_valid", 32'(bus.out_valid), 1);
            checkOutput("hold_data", 32'(bus.out_data), 32'(prev_data));
            checkOutput("hold_tag", 32'(bus.out_tag), 32'(prev_tag));
         end
         if (bus.in_valid && bus.in_ready) begin
            e.data = model_data(bus.in_data, int'(bus.in_shift), int'(bus.in_mode));
            e.tag  = bus.in_tag;
            e.ovf  = model_ovf(bus.in_data, int'(bus.in_shift), int'(bus.in_mode));
            sb.push_back(e);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_output", 32'(bus.out_valid), 0);
            end else begin
               e = sb.pop_front();
               checkOutput("sb_data", 32'(bus.out_data), 32'(e.data));
               checkOutput("sb_tag", 32'(bus.out_tag), 32'(e.tag));
`ifdef PIPELINED_BARREL_SHIFTER_OVERFLOW_EN
               checkOutput("sb_ovf", 32'(bus.out_overflow), 32'(e.ovf));
`endif
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_tag   = bus.out_tag;
      end
   end

   // Overall time limit so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence
   initial begin
      int guard;
      logic [W-1:0] rd;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_shift  = '0;
      bus.in_mode   = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", 32'(bus.out_valid), 0);
      checkOutput("reset_out_data", 32'(bus.out_data), 0);
      checkOutput("reset_out_tag", 32'(bus.out_tag), 0);
      checkOutput("reset_in_ready", 32'(bus.in_ready), 1);
`ifdef PIPELINED_BARREL_SHIFTER_OVERFLOW_EN
      checkOutput("reset_out_ovf", 32'(bus.out_overflow), 0);
`endif
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] directed operations");
      directedOp("t1_shl12", 13'h0001, 12, 0, 5, 13'h1000);
      directedOp("t2_sra4", 13'h1000, 4, 3, 1, 13'h1F00);
      directedOp("t2_shr4", 13'h1000, 4, 1, 2, 13'h0100);
      directedOp("t2_sra15", 13'h1000, 15, 3, 3, 13'h1FFF);
      directedOp("t3_rol1", 13'h1001, 1, 2, 4, 13'h0003);
      directedOp("t3_rol14", 13'h1001, 14, 2, 6, 13'h0003);
      directedOp("t3_shl14", 13'h1001, 14, 0, 7, 13'h0000);
      directedOp("t3_shr0", 13'h1ABC, 0, 1, 8, 13'h1ABC);
      directedOp("t3_sra0", 13'h1ABC, 0, 3, 9, 13'h1ABC);
`ifdef PIPELINED_BARREL_SHIFTER_OVERFLOW_EN
      directedOp("t6_shl5", 13'h0101, 5, 0, 10, 13'h0020);
      checkOutput("t6_shl5_ovf", 32'(last_ovf), 1);
      directedOp("t6_shl4", 13'h0101, 4, 0, 11, 13'h1010);
      checkOutput("t6_shl4_ovf", 32'(last_ovf), 0);
      directedOp("t6_rol3", 13'h1FFF, 3, 2, 12, 13'h1FFF);
      checkOutput("t6_rol3_ovf", 32'(last_ovf), 0);
      directedOp("t6_sra2", 13'h1002, 2, 3, 13, 13'h1C00);
      checkOutput("t6_sra2_ovf", 32'(last_ovf), 1);
`endif

      $display("[TB] backpressure");
      bus.out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) applyStimulus(W'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), i);
         end
         begin
            repeat (4) @(negedge clk);
            checkOutput("bp_in_ready_low", 32'(bus.in_ready), 0);
            checkOutput("bp_held_valid", 32'(bus.out_valid), 1);
            checkOutput("bp_held_tag", 32'(bus.out_tag), 0);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               checkOutput("bp_stream_valid", 32'(bus.out_valid), 1);
               checkOutput("bp_stream_tag", 32'(bus.out_tag), 32'(i));
            end
         end
      join
      @(posedge clk);
      #1;
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] reset with operands in flight");
      applyStimulus(13'h0F0F, 3, 0, 1);
      applyStimulus(13'h1234, 7, 2, 2);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_out_valid", 32'(bus.out_valid), 0);
      checkOutput("async_reset_in_ready", 32'(bus.in_ready), 1);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      checkOutput("post_reset_in_ready", 32'(bus.in_ready), 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("post_reset_no_stale", 32'(bus.out_valid), 0);
      end
      @(posedge clk);
      #1;

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 7))
            0:       rd = '1;
            1:       rd = '0;
            2:       rd = 13'h1000;
            default: rd = W'($urandom);
         endcase
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_data   = rd;
         bus.in_shift  = SB'($urandom_range(0, 15));
         bus.in_mode   = 2'($urandom_range(0, 3));
         bus.in_tag    = TW'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      guard = 0;
      while (sb.size() != 0 && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checkOutput("drain_empty", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, multi-mode successor to the fixed radix-4 pipelined left shifter. It supports logical left/right shift, arithmetic right shift and left rotate. The radix per stage is configurable, and a sideband tag travels with each operand. A valid/ready handshake with full per-stage stall support lets the block sit inside backpressured datapaths of the search engine.

Parameters:
WIDTH, 13, operand width in bits (>=2)
RADIX_BITS, 2, shift-amount bits resolved per pipeline stage (1..4)
TAG_WIDTH, 4, sideband tag width carried alongside data (>=1)
SHIFT_BITS, $clog2(WIDTH), derived; width of shift amount
STAGES, ceil(SHIFT_BITS/RADIX_BITS), derived; pipeline depth and latency

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input operand valid
in_ready  out  1  block can accept operand this cycle
in_data  in  WIDTH  operand
in_shift  in  SHIFT_BITS  shift amount, unsigned
in_mode  in  2  0=SHL logical, 1=SHR logical, 2=ROL rotate left, 3=SRA arithmetic right
in_tag  in  TAG_WIDTH  opaque sideband, returned unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  WIDTH  result
out_tag  out  TAG_WIDTH  tag of the result
out_overflow  out  1  present only with the optional feature; see below

Behaviour:
- Reset: asynchronous on reset_n low, cleared immediately. All stage valid bits, out_valid, out_data, out_tag and out_overflow are 0.
- Transfer rules: input transfers when in_valid && in_ready. Output transfers when out_valid && out_ready.
- Stage structure: STAGES register stages, each holding valid, data, tag, mode, remaining shift bits and overflow accumulator.
- Digit order: stage 0 resolves the most-significant RADIX_BITS digit of the shift amount (zero-padded on top to STAGES*RADIX_BITS); the last stage resolves the least-significant digit. Stage s shifts by digit*2^(RADIX_BITS*(STAGES-1-s)).
- Latency and throughput: exactly STAGES cycles from input transfer to out_valid when unstalled. One result per cycle sustained.
- Stall: stage k loads when it is empty or its contents advance to stage k+1 (last stage: when out_ready). in_ready = stage 0 loads. Bubbles collapse, so an empty stage fills even while later stages stall.
- No loss or duplication; strict in-order delivery. While stalled, out_data, out_tag and out_valid are held stable.
- Fill values:
  - SHL: zeros fill from the LSB.
  - SHR: zeros fill from the MSB.
  - SRA: the operand's original bit WIDTH-1 fills from the MSB at every stage.
  - ROL: bits wrap from the MSB back to the LSB.
- Shift amount >= WIDTH (possible when WIDTH is not a power of two):
  - SHL/SHR give 0.
  - SRA gives all sign bits.
  - ROL rotates by amount mod WIDTH; this falls out naturally from composing per-stage rotations.
- Shift amount 0: passes data unchanged in every mode.
- Simultaneous input and output transfer on a full pipeline is allowed (in_ready=1 when out_ready=1).

Optional Feature:
Macro PIPELINED_BARREL_SHIFTER_OVERFLOW_EN.
- Defined: out_overflow is present and aligned with out_data. It is 1 when a SHL result discarded at least one set bit, or an SRA result discarded at least one bit differing from the sign bit. Each stage ORs its dropped-bit check into the accumulator. It is always 0 for SHR and ROL.
- Undefined: the port, the accumulators and the logic are absent.

Test Plan:
(WIDTH=13, RADIX_BITS=2, so STAGES=2.)
1. SHL, in_data=13'h0001, shift=12, tag=5, out_ready=1 -> out_data=13'h1000, out_tag=5, out_valid exactly 2 cycles after acceptance.
2. SRA, in_data=13'h1000, shift=4 -> 13'h1F00. SHR with the same inputs -> 13'h0100. SRA with shift=15 -> 13'h1FFF.
3. ROL, in_data=13'h1001, shift=1 -> 13'h0003. ROL with shift=14 -> 13'h0003. SHL with shift=14 -> 13'h0000.
4. Backpressure: issue 6 back-to-back operands with tags 0..5, hold out_ready=0 for 4 cycles.
   - in_ready drops once both stages are full.
   - Outputs hold stable while stalled.
   - After release, tags 0..5 emerge in order, one per cycle, with no loss or duplication.
5. Reset mid-flight: drop reset_n asynchronously with 2 operands in flight -> out_valid=0 before the next clock edge. After release, in_ready=1 and no stale result appears.
6. With PIPELINED_BARREL_SHIFTER_OVERFLOW_EN defined:
   - SHL, 13'h0101, shift=5 -> out_overflow=1.
   - SHL, 13'h0101, shift=4 -> 13'h1010 with out_overflow=0.
   - ROL, 13'h1FFF, shift=3 -> out_overflow=0.
